// File: rtl/asu_seq_div.sv
// Iterative 16-bit restoring divider: one subtract-and-compare step per clock, 16 steps.
// Optional signed path enabled by defining ASU_DIV_SIGNED_EN.
module asu_seq_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        signed_op,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [15:0] dvs_q, dvs_d;
    logic [15:0] rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] quo_out_q, quo_out_d;
    logic [15:0] rem_out_q, rem_out_d;
    logic        dbz_q, dbz_d;

    logic [16:0] partial;
    logic [16:0] diff;
    logic        ge;
    logic [15:0] step_rem;
    logic [15:0] step_quo;
    logic [15:0] a_mag;
    logic [15:0] b_mag;
    logic [15:0] fix_quo;
    logic [15:0] fix_rem;

`ifdef ASU_DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic a_neg;
    logic b_neg;

    // Magnitudes are taken at capture; signs are reapplied when the outputs load.
    assign a_neg   = signed_op & in1[15];
    assign b_neg   = signed_op & in2[15];
    assign a_mag   = a_neg ? (~in1 + 16'd1) : in1;
    assign b_mag   = b_neg ? (~in2 + 16'd1) : in2;
    assign fix_quo = neg_quo_q ? (~step_quo + 16'd1) : step_quo;
    assign fix_rem = neg_rem_q ? (~step_rem + 16'd1) : step_rem;

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic signed_op_unused;

    assign signed_op_unused = signed_op;
    assign a_mag   = in1;
    assign b_mag   = in2;
    assign fix_quo = step_quo;
    assign fix_rem = step_rem;
`endif

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign partial  = {rem_q, dvd_q[15]};
    assign diff     = partial - {1'b0, dvs_q};
    assign ge       = (partial >= {1'b0, dvs_q});
    assign step_rem = ge ? diff[15:0] : partial[15:0];
    assign step_quo = {dvd_q[14:0], ge};

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (in2 == 16'd0) begin
                        state_d   = S_DONE;
                        quo_out_d = 16'hFFFF;
                        rem_out_d = in1;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = 16'd0;
                        cnt_d   = 4'd0;
                        dbz_d   = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                dvd_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d   = S_DONE;
                    quo_out_d = fix_quo;
                    rem_out_d = fix_rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            dvd_q     <= 16'd0;
            dvs_q     <= 16'd0;
            rem_q     <= 16'd0;
            cnt_q     <= 4'd0;
            quo_out_q <= 16'd0;
            rem_out_q <= 16'd0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign quotient    = quo_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);

endmodule
